// File: rtl/uart_rx_controller.sv
// uart_rx_controller: start-bit detect, baud generator control, 8N1 byte capture into a single-entry valid/ready buffer
module uart_rx_controller #(
  parameter int CLKS_PER_BIT = 10417,
  parameter int HALF_BIT     = CLKS_PER_BIT / 2,
  parameter int CNT_W        = 14
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       baud_tick,
  output logic       baud_en,
  output logic       baud_clr,
  output logic [7:0] data_out,
  output logic       data_valid,
  input  logic       data_ready,
  output logic       frame_err,
  output logic       overrun_err
);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;
  state_t state, state_n;
  logic [1:0] sync;
  logic [CNT_W-1:0] cnt;
  logic [2:0] idx;
  logic [7:0] shift;
  logic rx_s, half_done, stop_tick, stop_ok;
  assign rx_s      = sync[1];
  assign half_done = cnt == CNT_W'(HALF_BIT - 1);
  assign stop_tick = state == STOP && baud_tick;
  assign stop_ok   = stop_tick && rx_s;
  always_comb begin
    state_n  = state;
    baud_en  = 1'b0;
    baud_clr = 1'b0;
    unique case (state)
      IDLE:  state_n = rx_s ? IDLE : START;
      START: begin
        // the generator is restarted here so its ticks land mid-bit from now on
        baud_clr = half_done && !rx_s;
        baud_en  = half_done && !rx_s;
        state_n  = !half_done ? START : rx_s ? IDLE : DATA;
      end
      DATA: begin
        baud_en = 1'b1;
        state_n = baud_tick && idx == 3'd7 ? STOP : DATA;
      end
      STOP: begin
        baud_en = 1'b1;
        state_n = !baud_tick ? STOP : rx_s ? IDLE : BRK;
      end
      BRK:     state_n = rx_s ? IDLE : BRK;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      sync        <= 2'b11;
      cnt         <= '0;
      idx         <= '0;
      shift       <= '0;
      data_out    <= '0;
      data_valid  <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      state       <= state_n;
      sync        <= {sync[0], rx};
      cnt         <= state == START ? cnt + 1'b1 : '0;
      frame_err   <= stop_tick && !rx_s;
      overrun_err <= stop_ok && data_valid && !data_ready;
      if (state == START && half_done)
        idx <= '0;
      if (state == DATA && baud_tick) begin
        shift[idx] <= rx_s;
        idx        <= idx + 1'b1;
      end
      if (stop_ok && (!data_valid || data_ready)) begin
        data_out   <= shift;
        data_valid <= 1'b1;
      end else if (data_valid && data_ready)
        data_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_uart_rx_controller.sv
// tb_uart_rx_controller: directed frames with a byte scoreboard checked by a negedge monitor
module tb_uart_rx_controller;
  localparam int CPB = 16;
  logic clk = 1'b0, rst = 1'b1, rx = 1'b1, data_ready = 1'b0;
  logic baud_tick, baud_en, baud_clr, data_valid, frame_err, overrun_err;
  logic [7:0] data_out;
  int cyc = 0, bcnt = 0;
  int checks = 0, errors = 0;
  logic [7:0] exp_q[$];
  int fe_n = 0, ov_n = 0, exp_fe = 0, exp_ov = 0;
  int clr_n = 0, clr_cyc = 0, en_n = 0, tick_n = 0, stop_cyc = 0, rise_cyc = 0, valid_n = 0;
  int t0, c0, e0, v0;
  logic pv = 1'b0, pfe = 1'b0, pov = 1'b0, pacc = 1'b0;
  logic [7:0] pd = '0;

  always #5 clk = ~clk;

  // behavioural baud generator: tick CPB cycles after the clear was sampled
  always @(posedge clk) begin
    cyc  <= cyc + 1;
    bcnt <= baud_clr ? 0 : baud_en ? (bcnt == CPB - 1 ? 0 : bcnt + 1) : bcnt;
  end
  assign baud_tick = baud_en && bcnt == CPB - 1;

  uart_rx_controller #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .rx(rx), .baud_tick(baud_tick), .baud_en(baud_en),
    .baud_clr(baud_clr), .data_out(data_out), .data_valid(data_valid),
    .data_ready(data_ready), .frame_err(frame_err), .overrun_err(overrun_err)
  );

  task automatic chk(string n, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", n, act, act, exp, exp);
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(logic [7:0] b, logic stop);
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(CPB);
    end
    rx = stop;
    tick(CPB);
    rx = 1'b1;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      pv = 1'b0; pfe = 1'b0; pov = 1'b0; pacc = 1'b0;
    end else begin
      if (baud_clr) begin clr_n++; clr_cyc = cyc; tick_n = 0; end
      if (baud_en) en_n++;
      if (baud_tick) begin tick_n++; if (tick_n == 9) stop_cyc = cyc; end
      if (data_valid) valid_n++;
      if (data_valid && !pv) rise_cyc = cyc;
      if (pv && data_valid && !pacc) chk("hold_stable", data_out, pd);
      if (frame_err) begin fe_n++; chk("fe_width", pfe, 0); end
      if (overrun_err) begin ov_n++; chk("ov_width", pov, 0); end
      if (data_valid && data_ready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_byte: got 0x%0h expected none", data_out);
        end else chk("rx_byte", data_out, exp_q.pop_front());
      end
      pv = data_valid; pd = data_out; pfe = frame_err; pov = overrun_err;
      pacc = data_valid && data_ready;
    end
  end

  initial begin
    tick(3);
    chk("rst_valid", data_valid, 0);
    chk("rst_data", data_out, 0);
    chk("rst_en", baud_en, 0);
    chk("rst_clr", baud_clr, 0);
    chk("rst_errs", frame_err + overrun_err, 0);
    rst = 1'b0;
    tick(5);
    // good 0x55, consumer always ready
    data_ready = 1'b1;
    exp_q.push_back(8'h55);
    t0 = cyc; c0 = clr_n; v0 = valid_n;
    send(8'h55, 1'b1);
    tick(10);
    chk("t1_clr_count", clr_n - c0, 1);
    chk("t1_clr_delay", clr_cyc - t0, 10);
    chk("t1_stop_sample", stop_cyc - t0, 154);
    chk("t1_valid_rise", rise_cyc - stop_cyc, 1);
    chk("t1_valid_cycles", valid_n - v0, 1);
    chk("t1_errs", fe_n + ov_n, 0);
    // 0xA3 held until the consumer is ready
    data_ready = 1'b0;
    exp_q.push_back(8'hA3);
    send(8'hA3, 1'b1);
    tick(20);
    chk("t2_valid_rise", rise_cyc - stop_cyc, 1);
    chk("t2_valid_held", data_valid, 1);
    chk("t2_data", data_out, 8'hA3);
    data_ready = 1'b1;
    @(negedge clk) chk("t2_valid_at_accept", data_valid, 1);
    @(negedge clk) chk("t2_valid_drop", data_valid, 0);
    tick(1);
    // bad stop bit followed by a long break
    exp_fe++;
    c0 = clr_n; v0 = valid_n;
    send(8'h3C, 1'b0);
    rx = 1'b0;
    e0 = en_n;
    tick(50 * CPB);
    chk("t3_break_no_en", en_n - e0, 0);
    chk("t3_break_no_clr", clr_n - c0, 1);
    chk("t3_frame_err", fe_n, exp_fe);
    rx = 1'b1;
    tick(30);
    chk("t3_no_restart", clr_n - c0, 1);
    chk("t3_no_valid", valid_n - v0, 0);
    // short glitch on an idle line
    c0 = clr_n; e0 = en_n; v0 = valid_n;
    rx = 1'b0;
    tick(3);
    rx = 1'b1;
    tick(40);
    chk("t4_no_en", en_n - e0, 0);
    chk("t4_no_clr", clr_n - c0, 0);
    chk("t4_no_err", fe_n * 16 + ov_n, exp_fe * 16 + exp_ov);
    chk("t4_no_valid", valid_n - v0, 0);
    // back-to-back frames into a full buffer
    data_ready = 1'b0;
    exp_q.push_back(8'h11);
    exp_ov++;
    send(8'h11, 1'b1);
    send(8'h22, 1'b1);
    tick(10);
    chk("t5_overrun", ov_n, exp_ov);
    chk("t5_data_kept", data_out, 8'h11);
    chk("t5_valid", data_valid, 1);
    data_ready = 1'b1;
    tick(3);
    chk("t5_valid_clear", data_valid, 0);
    chk("t5_dropped", exp_q.size(), 0);
    // reset in the middle of a frame
    v0 = valid_n;
    fork
      send(8'hFF, 1'b1);
      begin
        tick(95);
        chk("t6_in_data", baud_en, 1);
        rst = 1'b1;
        tick(1);
        chk("t6_rst_en", baud_en, 0);
        chk("t6_rst_clr", baud_clr, 0);
        chk("t6_rst_valid", data_valid, 0);
        chk("t6_rst_data", data_out, 0);
        chk("t6_rst_errs", frame_err + overrun_err, 0);
        rst = 1'b0;
      end
    join
    tick(20);
    chk("t6_abandoned", valid_n - v0, 0);
    exp_q.push_back(8'h7E);
    send(8'h7E, 1'b1);
    tick(10);
    chk("t6_received", valid_n - v0, 1);
    chk("final_fe", fe_n, exp_fe);
    chk("final_ov", ov_n, exp_ov);
    chk("final_queue", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
